tqvp_prism_in_cond: RTL and testbench
=====================================

// Module: tqvp_prism_in_cond
// PURPOSE
//   Input-conditioning stage in front of the PRISM FSM input bus (prism_in_data[6:0]).
//   Per bit: synchronises the raw PMOD inputs, applies an optional glitch filter and
//   optional inversion, then produces single-cycle rise/fall pulses and sticky edge flags.
//   The peripheral wrapper routes cond_data to the FSM and exposes the flags and irq.
// PARAMETERS
//   WIDTH      8   number of conditioned input bits
//   FILT_BITS  3   width of the per-bit filter counter and of filt_len
// PORTS
//   clk        in   1          peripheral clock (64 MHz nominal)
//   rst_n      in   1          asynchronous active-low reset
//   ui_in      in   WIDTH      raw input pins (asynchronous to clk)
//   filt_en    in   WIDTH      per-bit glitch filter enable
//   filt_len   in   FILT_BITS  filter length N, shared by all bits
//   invert     in   WIDTH      per-bit output inversion
//   edge_pol   in   WIDTH      per-bit flag edge: 1 = rising, 0 = falling
//   flag_clr   in   WIDTH      per-bit sticky-flag clear, one-cycle pulse
//   irq_en     in   WIDTH      per-bit interrupt enable
//   cond_data  out  WIDTH      conditioned level: stable ^ invert
//   rise       out  WIDTH      1-cycle pulse on a 0->1 change of cond_data
//   fall       out  WIDTH      1-cycle pulse on a 1->0 change of cond_data
//   edge_flag  out  WIDTH      sticky edge flags
//   irq        out  1          |(edge_flag & irq_en)
// BEHAVIOUR
//   - Reset (async, all flops): sync1, sync2, stable, cnt, cond_prev, edge_flag = 0; armed = 0.
//     Outputs during reset: cond_data = invert; rise = fall = edge_flag = 0; irq = 0.
//   - Synchroniser: two flops per bit, sync1 <= ui_in and sync2 <= sync1. No reset-less flops.
//   - Filter, per bit i, with N = filt_en[i] ? filt_len : 0:
//       if sync2[i] == stable[i]  : cnt[i] <= 0
//       else if cnt[i] == N       : stable[i] <= sync2[i]; cnt[i] <= 0
//       else                      : cnt[i] <= cnt[i] + 1  (cannot wrap: it stops at N <= 2^FILT_BITS-1)
//     A change must persist for N+1 consecutive sync2 samples. Shorter pulses are discarded
//     and the counter restarts from 0 on any sample that matches stable.
//   - Latency from ui_in (meeting setup at edge k) to cond_data change: edge k+2+N (N = 0: 3 edges).
//   - Changing filt_len mid-count: the new N applies at the next compare. If cnt > new N, the
//     counter keeps counting until cnt == N after wrap; implement it as cnt >= N to force an
//     immediate update instead (required behaviour: update on the next differing sample).
//   - Edge detect: cond_prev <= cond_data each cycle. armed <= 1 one cycle after reset release.
//     rise = armed & cond_data & ~cond_prev; fall = armed & ~cond_data & cond_prev (combinational
//     from registers, asserted in the first cycle cond_data shows the new value).
//   - Toggling invert[i] changes cond_data[i] and DOES generate an edge. Software clears the
//     flags after reconfiguring.
//   - Sticky flags: sel = edge_pol ? rise : fall. edge_flag[i] <= sel[i] | (edge_flag[i] & ~flag_clr[i]).
//     A set in the same cycle as a clear wins: the flag stays 1.
//   - irq is combinational from the edge_flag registers and irq_en. No extra latency.
//   - Reset mid-filter: the count is lost. The filter re-acquires from stable = 0 after release,
//     so an input held at 1 yields cond_data rising 3+N edges after release, with a rise pulse
//     because armed is already 1.
// TESTING
//   1 Reset, invert=0x00, filt_en=0; drive ui_in 0x00->0x05 -> cond_data=0x05 on edge 3,
//     rise=0x05 for exactly 1 cycle, fall=0.
//   2 filt_en=0x01, filt_len=3; 3-cycle high glitch on ui_in[0] -> no cond_data change, no
//     pulse. 4-cycle high -> cond_data[0]=1 on edge 6.
//   3 invert=0x80 after reset -> cond_data=0x80 with no rise/fall pulse. Toggle invert to 0x00
//     -> fall[7] pulse.
//   4 edge_pol=0x02, irq_en=0x02; rise on bit 1 -> edge_flag=0x02, irq=1. flag_clr=0x02 in the
//     same cycle as a new rise -> flag stays 1; clear alone -> flag=0, irq=0.
//   5 filt_len=7 mid-count at cnt=5, then filt_len set to 2 -> stable updates on the next
//     differing sample.
//   6 Assert rst_n low during a filter count with ui_in[2]=1 -> all outputs 0/invert immediately.
//     After release, cond_data[2]=1 at edge 3+N with a rise[2] pulse.

Source files
------------

// File: rtl/tqvp_prism_in_cond.sv
// Input conditioning in front of the PRISM FSM input bus.
// Sync, glitch filter, inversion, edge pulses and sticky flags.
module tqvp_prism_in_cond #(
    parameter int WIDTH     = 8,
    parameter int FILT_BITS = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     ui_in,
    input  logic [WIDTH-1:0]     filt_en,
    input  logic [FILT_BITS-1:0] filt_len,
    input  logic [WIDTH-1:0]     invert,
    input  logic [WIDTH-1:0]     edge_pol,
    input  logic [WIDTH-1:0]     flag_clr,
    input  logic [WIDTH-1:0]     irq_en,
    output logic [WIDTH-1:0]     cond_data,
    output logic [WIDTH-1:0]     rise,
    output logic [WIDTH-1:0]     fall,
    output logic [WIDTH-1:0]     edge_flag,
    output logic                 irq
);

    localparam logic [FILT_BITS-1:0] CNT_ONE = FILT_BITS'(1);

    logic [WIDTH-1:0]     sync1;
    logic [WIDTH-1:0]     sync2;
    logic [WIDTH-1:0]     stable;
    logic [WIDTH-1:0]     cond_prev;
    logic                 armed;
    logic [FILT_BITS-1:0] cnt   [WIDTH];
    logic [FILT_BITS-1:0] n_len [WIDTH];
    logic [WIDTH-1:0]     sel;

    // Two-flop synchroniser for the asynchronous pin inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= ui_in;
            sync2 <= sync1;
        end
    end

    // Effective filter length per bit; a disabled filter passes after one sample.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            n_len[i] = filt_en[i] ? filt_len : '0;
        end
    end

    // Glitch filter: a change must persist for N+1 samples; >= lets a shortened
    // length take effect on the very next differing sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] >= n_len[i]) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_ONE;
                end
            end
        end
    end

    assign cond_data = stable ^ invert;

    // Previous conditioned level and the arm bit that masks the first cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cond_prev <= '0;
            armed     <= 1'b0;
        end else begin
            cond_prev <= cond_data;
            armed     <= 1'b1;
        end
    end

    assign rise = {WIDTH{armed}} & cond_data & ~cond_prev;
    assign fall = {WIDTH{armed}} & ~cond_data & cond_prev;
    assign sel  = (edge_pol & rise) | (~edge_pol & fall);

    // Sticky flags; a new edge in the clear cycle keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_flag <= '0;
        end else begin
            edge_flag <= sel | (edge_flag & ~flag_clr);
        end
    end

    assign irq = |(edge_flag & irq_en);

endmodule

// File: tb/tb_tqvp_prism_in_cond.sv
// Directed bench for tqvp_prism_in_cond.
// Inputs change #1 after a rising edge; outputs are sampled there too.
module tb_tqvp_prism_in_cond;

    logic       clk;
    logic       rst_n;
    logic [7:0] ui_in;
    logic [7:0] filt_en;
    logic [2:0] filt_len;
    logic [7:0] invert;
    logic [7:0] edge_pol;
    logic [7:0] flag_clr;
    logic [7:0] irq_en;
    logic [7:0] cond_data;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] edge_flag;
    logic       irq;

    int errors = 0;
    int checks = 0;

    tqvp_prism_in_cond #(.WIDTH(8), .FILT_BITS(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ui_in     (ui_in),
        .filt_en   (filt_en),
        .filt_len  (filt_len),
        .invert    (invert),
        .edge_pol  (edge_pol),
        .flag_clr  (flag_clr),
        .irq_en    (irq_en),
        .cond_data (cond_data),
        .rise      (rise),
        .fall      (fall),
        .edge_flag (edge_flag),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        ui_in    = '0;
        filt_en  = '0;
        filt_len = '0;
        invert   = '0;
        edge_pol = '0;
        flag_clr = '0;
        irq_en   = '0;
        step(2);
        rst_n = 1'b1;
        step(3);
    endtask

    task automatic test_reset();
        do_reset();
        rst_n  = 1'b0;
        invert = 8'h3C;
        #1;
        checks++;
        if (cond_data !== 8'h3C) begin
            errors++;
            $display("FAIL reset_cond: got %h want %h", cond_data, 8'h3C);
        end
        checks++;
        if ({rise, fall, edge_flag, irq} !== 25'd0) begin
            errors++;
            $display("FAIL reset_outs: rise=%h fall=%h flag=%h irq=%b want 0",
                     rise, fall, edge_flag, irq);
        end
        invert = '0;
        step(1);
        rst_n = 1'b1;
        step(3);
    endtask

    task automatic test_basic();
        do_reset();
        ui_in = 8'h05;
        step(2);
        checks++;
        if (cond_data !== 8'h00) begin
            errors++;
            $display("FAIL basic_early: got %h want 00", cond_data);
        end
        step(1);
        checks++;
        if (cond_data !== 8'h05 || rise !== 8'h05 || fall !== 8'h00) begin
            errors++;
            $display("FAIL basic_edge3: cond=%h rise=%h fall=%h want 05 05 00",
                     cond_data, rise, fall);
        end
        step(1);
        checks++;
        if (cond_data !== 8'h05 || rise !== 8'h00) begin
            errors++;
            $display("FAIL basic_pulse: cond=%h rise=%h want 05 00", cond_data, rise);
        end
    endtask

    task automatic test_filter();
        logic [7:0] seen;
        do_reset();
        filt_en  = 8'h01;
        filt_len = 3'd3;
        seen     = '0;
        ui_in    = 8'h01;
        for (int i = 0; i < 3; i++) begin
            step(1);
            seen = seen | cond_data | rise | fall;
        end
        ui_in = 8'h00;
        for (int i = 0; i < 8; i++) begin
            step(1);
            seen = seen | cond_data | rise | fall;
        end
        checks++;
        if (seen !== 8'h00) begin
            errors++;
            $display("FAIL filt_glitch: activity=%h want 00", seen);
        end
        ui_in = 8'h01;
        step(4);
        ui_in = 8'h00;
        step(1);
        checks++;
        if (cond_data !== 8'h00) begin
            errors++;
            $display("FAIL filt_edge5: got %h want 00", cond_data);
        end
        step(1);
        checks++;
        if (cond_data !== 8'h01 || rise !== 8'h01) begin
            errors++;
            $display("FAIL filt_edge6: cond=%h rise=%h want 01 01", cond_data, rise);
        end
    endtask

    task automatic test_invert();
        logic [7:0] seen;
        rst_n    = 1'b0;
        ui_in    = '0;
        filt_en  = '0;
        filt_len = '0;
        invert   = 8'h80;
        edge_pol = '0;
        flag_clr = '0;
        irq_en   = '0;
        step(2);
        rst_n = 1'b1;
        seen  = '0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            seen = seen | rise | fall;
        end
        checks++;
        if (cond_data !== 8'h80 || seen !== 8'h00) begin
            errors++;
            $display("FAIL inv_static: cond=%h pulses=%h want 80 00", cond_data, seen);
        end
        invert = 8'h00;
        #1;
        checks++;
        if (cond_data !== 8'h00 || fall !== 8'h80 || rise !== 8'h00) begin
            errors++;
            $display("FAIL inv_toggle: cond=%h fall=%h rise=%h want 00 80 00",
                     cond_data, fall, rise);
        end
        step(1);
        checks++;
        if (fall !== 8'h00 || edge_flag !== 8'h80) begin
            errors++;
            $display("FAIL inv_flag: fall=%h flag=%h want 00 80", fall, edge_flag);
        end
    endtask

    task automatic test_flags();
        do_reset();
        edge_pol = 8'h02;
        irq_en   = 8'h02;
        ui_in    = 8'h02;
        step(3);
        checks++;
        if (rise !== 8'h02 || edge_flag !== 8'h00 || irq !== 1'b0) begin
            errors++;
            $display("FAIL flag_pre: rise=%h flag=%h irq=%b want 02 00 0",
                     rise, edge_flag, irq);
        end
        step(1);
        checks++;
        if (edge_flag !== 8'h02 || irq !== 1'b1) begin
            errors++;
            $display("FAIL flag_set: flag=%h irq=%b want 02 1", edge_flag, irq);
        end
        ui_in = 8'h00;
        step(5);
        ui_in = 8'h02;
        step(3);
        flag_clr = 8'h02;
        step(1);
        flag_clr = 8'h00;
        checks++;
        if (edge_flag !== 8'h02 || irq !== 1'b1) begin
            errors++;
            $display("FAIL flag_set_wins: flag=%h irq=%b want 02 1", edge_flag, irq);
        end
        flag_clr = 8'h02;
        step(1);
        flag_clr = 8'h00;
        checks++;
        if (edge_flag !== 8'h00 || irq !== 1'b0) begin
            errors++;
            $display("FAIL flag_clear: flag=%h irq=%b want 00 0", edge_flag, irq);
        end
    endtask

    task automatic test_retune();
        do_reset();
        filt_en  = 8'h01;
        filt_len = 3'd7;
        ui_in    = 8'h01;
        step(7);
        checks++;
        if (cond_data !== 8'h00) begin
            errors++;
            $display("FAIL retune_hold: got %h want 00", cond_data);
        end
        filt_len = 3'd2;
        step(1);
        checks++;
        if (cond_data !== 8'h01 || rise !== 8'h01) begin
            errors++;
            $display("FAIL retune_update: cond=%h rise=%h want 01 01", cond_data, rise);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        filt_en  = 8'h04;
        filt_len = 3'd3;
        ui_in    = 8'h04;
        step(4);
        rst_n  = 1'b0;
        invert = 8'h40;
        #1;
        checks++;
        if (cond_data !== 8'h40 || rise !== 8'h00 || fall !== 8'h00 ||
            edge_flag !== 8'h00 || irq !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_outs: cond=%h rise=%h fall=%h flag=%h irq=%b",
                     cond_data, rise, fall, edge_flag, irq);
        end
        step(1);
        rst_n = 1'b1;
        step(5);
        checks++;
        if (cond_data !== 8'h40) begin
            errors++;
            $display("FAIL rstmid_early: got %h want 40", cond_data);
        end
        step(1);
        checks++;
        if (cond_data !== 8'h44 || rise !== 8'h04) begin
            errors++;
            $display("FAIL rstmid_reacq: cond=%h rise=%h want 44 04", cond_data, rise);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        ui_in    = '0;
        filt_en  = '0;
        filt_len = '0;
        invert   = '0;
        edge_pol = '0;
        flag_clr = '0;
        irq_en   = '0;
        test_reset();
        test_basic();
        test_filter();
        test_invert();
        test_flags();
        test_retune();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
